// File: rtl/osc_divider_arbiter_pkg.sv
// Shared types and helpers for the encoder/decoder oscillator divider arbiter.
// Declares the FSM state type, the default ratio width and the half-period calculation.
package osc_div_arb_pkg;

    localparam int unsigned DIV_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN
    } state_t;

    // Ratios below 2 would give a zero half-period; clamp so the output toggles every edge.
    function automatic int unsigned half_of(input int unsigned div);
        return (div < 2) ? 1 : (div >> 1);
    endfunction

endpackage

// File: rtl/osc_divider_arbiter_if.sv
// Request/grant and divided-clock bundle between the two requesters and the arbiter.
// The master side drives requests and ratios; the slave side is the arbiter.
interface osc_divider_arbiter_if
    import osc_div_arb_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
);
    logic [1:0]       REQ;
    logic [DIV_W-1:0] DIV0;
    logic [DIV_W-1:0] DIV1;
    logic [1:0]       GNT;
    logic             OSC_CLK;
    logic             OSC_RISE;
    logic             BUSY;

    modport master (
        output REQ, DIV0, DIV1,
        input  GNT, OSC_CLK, OSC_RISE, BUSY
    );

    modport slave (
        input  REQ, DIV0, DIV1,
        output GNT, OSC_CLK, OSC_RISE, BUSY
    );
endinterface

// File: rtl/osc_divider_arbiter_half_counter.sv
// Half-period counter: toggles OSC_CLK every HALF enabled cycles and pulses OSC_RISE on rising toggles.
// Dropping EN (outside LOAD) returns the counter and outputs to their idle zero state.
module osc_half_counter #(
    parameter int unsigned HW = 15
) (
    input  logic          INPUT_CLK,
    input  logic          RST,
    input  logic          LOAD,
    input  logic          EN,
    input  logic [HW-1:0] HALF,
    output logic          OSC_CLK,
    output logic          OSC_RISE,
    output logic          TOGGLE
);
    logic [HW-1:0] count_q;
    logic          osc_q;
    logic          rise_q;

    assign TOGGLE   = EN && (count_q == HALF);
    assign OSC_CLK  = osc_q;
    assign OSC_RISE = rise_q;

    always_ff @(posedge INPUT_CLK) begin
        if (RST) begin
            count_q <= '0;
            osc_q   <= 1'b0;
            rise_q  <= 1'b0;
        end else if (LOAD) begin
            count_q <= HW'(1);
            osc_q   <= 1'b0;
            rise_q  <= 1'b0;
        end else if (EN) begin
            if (TOGGLE) begin
                count_q <= HW'(1);
                osc_q   <= ~osc_q;
                rise_q  <= ~osc_q;
            end else begin
                count_q <= count_q + HW'(1);
                rise_q  <= 1'b0;
            end
        end else begin
            count_q <= '0;
            osc_q   <= 1'b0;
            rise_q  <= 1'b0;
        end
    end
endmodule

// File: rtl/osc_divider_arbiter.sv
// Round-robin arbiter sharing one programmable divider between the PT2262 encoder and PT2272 decoder.
// Holds the grant FSM, the round-robin pointer and the ratio mux; releases only on a low phase.
module osc_divider_arbiter
    import osc_div_arb_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic                   INPUT_CLK,
    input  logic                   RST,
    osc_divider_arbiter_if.slave   bus
);
    localparam int unsigned HW = DIV_W - 1;

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [HW-1:0] half_q;
    logic          idx;
    logic          rel;
    logic          osc;
    logic          rise;
    logic          toggle;
    logic          cnt_en;
    logic          cnt_load;
    logic [DIV_W-1:0] div_sel;

    assign idx     = gnt_q[1];
    assign rel     = ~bus.REQ[idx];
    assign div_sel = idx ? bus.DIV1 : bus.DIV0;

    // Leaving RUN from a low phase must not let a pending rising toggle escape as a runt pulse.
    assign cnt_en   = (state_q == DRAIN) || ((state_q == RUN) && !(rel && !osc));
    assign cnt_load = (state_q == LOAD);

    osc_half_counter #(
        .HW(HW)
    ) u_half_counter (
        .INPUT_CLK (INPUT_CLK),
        .RST       (RST),
        .LOAD      (cnt_load),
        .EN        (cnt_en),
        .HALF      (half_q),
        .OSC_CLK   (osc),
        .OSC_RISE  (rise),
        .TOGGLE    (toggle)
    );

    always_ff @(posedge INPUT_CLK) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= 1'b1;
            half_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            if (state_q == LOAD) begin
                half_q <= HW'(half_of(32'(div_sel)));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (bus.REQ != 2'b00) begin
                    state_d = LOAD;
                    if (bus.REQ == 2'b11) begin
                        gnt_d = last_q ? 2'b01 : 2'b10;
                    end else begin
                        gnt_d = bus.REQ;
                    end
                end
            end
            LOAD: begin
                state_d = RUN;
            end
            RUN: begin
                // A high phase that is already at its falling toggle can release immediately.
                if (rel && (!osc || toggle)) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    last_d  = idx;
                end else if (rel) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (toggle) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    last_d  = idx;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign bus.GNT      = gnt_q;
    assign bus.OSC_CLK  = osc;
    assign bus.OSC_RISE = rise;
    assign bus.BUSY     = (state_q != IDLE);
endmodule

// File: tb/tb_osc_divider_arbiter.sv
// Directed bench for osc_divider_arbiter: each step queues the expected post-edge outputs
// {GNT, OSC_CLK, OSC_RISE, BUSY}; a monitor on the falling edge pops and compares.
module tb_osc_divider_arbiter;
    import osc_div_arb_pkg::*;

    logic clk;
    logic rst;

    osc_divider_arbiter_if #(.DIV_W(16)) bus ();

    osc_divider_arbiter #(
        .DIV_W(16)
    ) dut (
        .INPUT_CLK (clk),
        .RST       (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  exp;
        int unsigned id;
    } exp_t;

    exp_t        sb[$];
    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned step_id = 0;

    // Inputs change at negedge+1, so the monitor's negedge never coincides with a push.
    task automatic step(input logic r, input logic [1:0] req, input logic [15:0] d0,
                        input logic [15:0] d1, input logic [4:0] exp);
        exp_t e;
        rst      = r;
        bus.REQ  = req;
        bus.DIV0 = d0;
        bus.DIV1 = d1;
        e.exp = exp;
        e.id  = step_id;
        sb.push_back(e);
        step_id++;
        @(negedge clk);
        #1;
    endtask

    task automatic run(input logic [1:0] req, input logic [15:0] d0, input logic [15:0] d1,
                       input logic [4:0] exp);
        step(1'b0, req, d0, d1, exp);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [4:0] act;
            e   = sb.pop_front();
            act = {bus.GNT, bus.OSC_CLK, bus.OSC_RISE, bus.BUSY};
            total++;
            if (act === e.exp) begin
                passed++;
            end else begin
                $display("FAIL step %0d gnt/osc/rise/busy: got %b_%b_%b_%b need %b_%b_%b_%b",
                         e.id, act[4:3], act[2], act[1], act[0],
                         e.exp[4:3], e.exp[2], e.exp[1], e.exp[0]);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        bus.REQ  = 2'b00;
        bus.DIV0 = 16'd4;
        bus.DIV1 = 16'd2;
        @(negedge clk);
        #1;

        // Reset, then encoder alone with DIV0=4 (HALF=2).
        step(1'b1, 2'b00, 16'd4, 16'd2, 5'b00_0_0_0);
        step(1'b1, 2'b00, 16'd4, 16'd2, 5'b00_0_0_0);
        run(2'b01, 16'd4, 16'd2, 5'b01_0_0_1); // E0 grant
        run(2'b01, 16'd4, 16'd2, 5'b01_0_0_1); // E1 load
        run(2'b01, 16'd4, 16'd2, 5'b01_0_0_1);
        run(2'b01, 16'd4, 16'd2, 5'b01_1_1_1); // E3 rise
        run(2'b01, 16'd4, 16'd2, 5'b01_1_0_1);
        run(2'b01, 16'd4, 16'd2, 5'b01_0_0_1); // E5 fall
        run(2'b01, 16'd4, 16'd2, 5'b01_0_0_1);
        run(2'b01, 16'd4, 16'd2, 5'b01_1_1_1); // E7 rise
        run(2'b01, 16'd4, 16'd2, 5'b01_1_0_1);
        run(2'b00, 16'd4, 16'd2, 5'b00_0_0_0); // release on the falling toggle
        run(2'b00, 16'd4, 16'd2, 5'b00_0_0_0);

        // Round robin: tie from reset goes to requester 0, then 1, then 0 again.
        step(1'b1, 2'b00, 16'd2, 16'd2, 5'b00_0_0_0);
        run(2'b11, 16'd2, 16'd2, 5'b01_0_0_1);
        run(2'b11, 16'd2, 16'd2, 5'b01_0_0_1);
        run(2'b11, 16'd2, 16'd2, 5'b01_1_1_1);
        run(2'b11, 16'd2, 16'd2, 5'b01_0_0_1);
        run(2'b10, 16'd2, 16'd2, 5'b00_0_0_0); // release 0 from a low phase
        run(2'b10, 16'd2, 16'd2, 5'b10_0_0_1); // requester 1 one cycle later
        run(2'b10, 16'd2, 16'd2, 5'b10_0_0_1);
        run(2'b10, 16'd2, 16'd2, 5'b10_1_1_1);
        run(2'b10, 16'd2, 16'd2, 5'b10_0_0_1);
        run(2'b00, 16'd2, 16'd2, 5'b00_0_0_0);
        run(2'b11, 16'd2, 16'd2, 5'b01_0_0_1);
        run(2'b11, 16'd2, 16'd2, 5'b01_0_0_1);

        // DIV0=6 (HALF=3): release during high phase drains to the falling edge.
        step(1'b1, 2'b00, 16'd6, 16'd2, 5'b00_0_0_0);
        run(2'b01, 16'd6, 16'd2, 5'b01_0_0_1);
        run(2'b01, 16'd6, 16'd2, 5'b01_0_0_1);
        run(2'b01, 16'd6, 16'd2, 5'b01_0_0_1);
        run(2'b01, 16'd6, 16'd2, 5'b01_0_0_1);
        run(2'b01, 16'd6, 16'd2, 5'b01_1_1_1);
        run(2'b00, 16'd6, 16'd2, 5'b01_1_0_1); // enters drain
        run(2'b01, 16'd6, 16'd2, 5'b01_1_0_1); // re-request ignored in drain
        run(2'b01, 16'd6, 16'd2, 5'b00_0_0_0); // falls, grant drops together
        run(2'b01, 16'd6, 16'd2, 5'b01_0_0_1); // re-arbitrated from idle
        run(2'b01, 16'd6, 16'd2, 5'b01_0_0_1);
        run(2'b00, 16'd6, 16'd2, 5'b00_0_0_0);

        // DIV0=0 and DIV0=1 both clamp to HALF=1.
        for (int unsigned d = 0; d < 2; d++) begin
            run(2'b01, 16'(d), 16'd2, 5'b01_0_0_1);
            run(2'b01, 16'(d), 16'd2, 5'b01_0_0_1);
            run(2'b01, 16'(d), 16'd2, 5'b01_1_1_1);
            run(2'b01, 16'(d), 16'd2, 5'b01_0_0_1);
            run(2'b01, 16'(d), 16'd2, 5'b01_1_1_1);
            run(2'b00, 16'(d), 16'd2, 5'b00_0_0_0);
            run(2'b00, 16'(d), 16'd2, 5'b00_0_0_0);
        end

        // DIV0=7 rounds down to HALF=3, period 6.
        run(2'b01, 16'd7, 16'd2, 5'b01_0_0_1);
        run(2'b01, 16'd7, 16'd2, 5'b01_0_0_1);
        run(2'b01, 16'd7, 16'd2, 5'b01_0_0_1);
        run(2'b01, 16'd7, 16'd2, 5'b01_0_0_1);
        run(2'b01, 16'd7, 16'd2, 5'b01_1_1_1);
        run(2'b01, 16'd7, 16'd2, 5'b01_1_0_1);
        run(2'b01, 16'd7, 16'd2, 5'b01_1_0_1);
        run(2'b01, 16'd7, 16'd2, 5'b01_0_0_1);
        run(2'b01, 16'd7, 16'd2, 5'b01_0_0_1);
        run(2'b01, 16'd7, 16'd2, 5'b01_0_0_1);
        run(2'b01, 16'd7, 16'd2, 5'b01_1_1_1);
        run(2'b00, 16'd7, 16'd2, 5'b01_1_0_1);
        run(2'b00, 16'd7, 16'd2, 5'b01_1_0_1);
        run(2'b00, 16'd7, 16'd2, 5'b00_0_0_0);

        // Ratio change after load is ignored: period stays 4.
        run(2'b01, 16'd4,  16'd2, 5'b01_0_0_1);
        run(2'b01, 16'd4,  16'd2, 5'b01_0_0_1);
        run(2'b01, 16'd10, 16'd2, 5'b01_0_0_1);
        run(2'b01, 16'd10, 16'd2, 5'b01_1_1_1);
        run(2'b01, 16'd10, 16'd2, 5'b01_1_0_1);
        run(2'b01, 16'd10, 16'd2, 5'b01_0_0_1);
        run(2'b01, 16'd10, 16'd2, 5'b01_0_0_1);
        run(2'b01, 16'd10, 16'd2, 5'b01_1_1_1);

        // Reset mid-RUN with OSC_CLK high: no drain, and LAST returns to 1.
        step(1'b1, 2'b01, 16'd10, 16'd2, 5'b00_0_0_0);
        run(2'b11, 16'd10, 16'd2, 5'b01_0_0_1);
        run(2'b11, 16'd10, 16'd2, 5'b01_0_0_1);
        run(2'b11, 16'd10, 16'd2, 5'b01_0_0_1);

        @(negedge clk);
        #1;
        total++;
        if (sb.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending entries need 0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
